// File: rtl/lsm_sequencer.sv
// Block data transfer (LDM/STM) sequencer: walks the register list one beat per ack.
// Optional macro LSM_PC_LOAD_FLUSH_EN enables the PC_LOADED pulse on a load into R15.
module lsm_sequencer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] IR,
  input  logic [31:0] BASE,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  REG_COUNTER,
  output logic        LSM_RD_MUX,
  output logic        LATCH_REG,
  output logic        WRITE_BACK,
  output logic [31:0] WB_DATA,
  output logic        PC_LOADED,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q;
  logic [31:0] addr_q;
  logic [31:0] wb_data_q;
  logic        l_q;
  logic        w_q;
  logic        skip_wb_q;

  // Instruction fields this block does not look at (condition, opcode class, S bit).
  logic unused_ir;
  assign unused_ir = ^{IR[31:25], IR[22]};

  logic [15:0] ir_list;
  logic [3:0]  ir_rn;
  logic        ir_p, ir_u;
  assign ir_list = IR[15:0];
  assign ir_rn   = IR[19:16];
  assign ir_p    = IR[24];
  assign ir_u    = IR[23];

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Start address and final base value, evaluated only when start is accepted.
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_value;

  always_comb begin
    span = 32'(popcount16(ir_list)) * STRIDE;
    unique case ({ir_p, ir_u})
      2'b01:   start_addr = BASE;
      2'b11:   start_addr = BASE + STRIDE;
      2'b00:   start_addr = BASE - span + STRIDE;
      default: start_addr = BASE - span;
    endcase
    wb_value = ir_u ? (BASE + span) : (BASE - span);
  end

  // Lowest pending register: isolate the lowest set bit and encode its index.
  logic [15:0] lowest_onehot;
  logic [3:0]  reg_idx;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    lowest_onehot = mask_q & (~mask_q + 16'd1);
    reg_idx       = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) reg_idx = 4'(i);
    end
  end

  logic beat_done;
  logic last_beat;
  assign beat_done = (state_q == XFER) && mem_ack;
  assign last_beat = (mask_q & ~lowest_onehot) == 16'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (ir_list == 16'd0) ? DONE : XFER;
      end
      XFER: begin
        if (beat_done && last_beat) state_d = (w_q && !skip_wb_q) ? WB : DONE;
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= 16'd0;
      addr_q    <= 32'd0;
      wb_data_q <= 32'd0;
      l_q       <= 1'b0;
      w_q       <= 1'b0;
      skip_wb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        mask_q    <= ir_list;
        addr_q    <= start_addr;
        wb_data_q <= wb_value;
        l_q       <= IR[20];
        w_q       <= IR[21];
        // A load that includes the base register keeps the loaded value.
        skip_wb_q <= IR[20] && ir_list[ir_rn];
      end else if (beat_done) begin
        mask_q <= mask_q & ~lowest_onehot;
        addr_q <= addr_q + STRIDE;
      end
    end
  end

  assign mem_req     = (state_q == XFER);
  assign mem_addr    = mem_req ? addr_q : 32'd0;
  assign mem_we      = mem_req && !l_q;
  assign REG_COUNTER = reg_idx;
  assign LSM_RD_MUX  = mem_req && l_q;
  assign LATCH_REG   = beat_done && l_q;
  assign WRITE_BACK  = (state_q == WB);
  assign WB_DATA     = wb_data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

`ifdef LSM_PC_LOAD_FLUSH_EN
  assign PC_LOADED = LATCH_REG && (reg_idx == 4'd15);
`else
  assign PC_LOADED = 1'b0;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: a list-level model queues expected beats,
// write-backs and completions; a negedge monitor compares what the DUT presents.
module tb_lsm_sequencer;

  localparam int unsigned WB_BYTES = 4;
`ifdef LSM_PC_LOAD_FLUSH_EN
  localparam bit PCL_EN = 1'b1;
`else
  localparam bit PCL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, mem_ack;
  logic [31:0] IR, BASE;
  logic        mem_req, mem_we, LSM_RD_MUX, LATCH_REG, WRITE_BACK, PC_LOADED, busy, done;
  logic [31:0] mem_addr, WB_DATA;
  logic [3:0]  REG_COUNTER;

  lsm_sequencer #(.WORD_BYTES(WB_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .IR(IR), .BASE(BASE), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .REG_COUNTER(REG_COUNTER),
    .LSM_RD_MUX(LSM_RD_MUX), .LATCH_REG(LATCH_REG), .WRITE_BACK(WRITE_BACK),
    .WB_DATA(WB_DATA), .PC_LOADED(PC_LOADED), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BEAT, EV_WB, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  reg_idx;
    logic [31:0] value;
    logic        we;
    logic        ld;
    logic        pcl;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT presented an event the model did not predict (t=%0t)", name, $time);
  endtask

  // Reference model: list order, address range and base update straight from the ISA rules.
  task automatic model(input logic [31:0] ir, input logic [31:0] base, output int lat);
    bit          p, u, w, l, do_wb;
    int          n, k;
    logic [3:0]  rn;
    logic [15:0] list;
    logic [31:0] span, lowest;
    ev_t         e;
    p = ir[24]; u = ir[23]; w = ir[21]; l = ir[20];
    rn = ir[19:16]; list = ir[15:0];
    n = $countones(list);
    span = 32'(n * WB_BYTES);
    if (u) lowest = p ? base + WB_BYTES : base;
    else   lowest = p ? base - span : base - span + WB_BYTES;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        e.kind = EV_BEAT; e.reg_idx = 4'(i); e.value = lowest + 32'(k * WB_BYTES);
        e.we = !l; e.ld = l; e.pcl = PCL_EN && l && (i == 15);
        exp_q.push_back(e);
        k++;
      end
    end
    do_wb = w && (n != 0) && !(l && list[rn]);
    if (do_wb) begin
      e.kind = EV_WB; e.reg_idx = 4'd0; e.value = u ? base + span : base - span;
      e.we = 0; e.ld = 0; e.pcl = 0;
      exp_q.push_back(e);
    end
    e.kind = EV_DONE; e.reg_idx = 4'd0; e.value = 32'd0; e.we = 0; e.ld = 0; e.pcl = 0;
    exp_q.push_back(e);
    lat = n + 1 + int'(do_wb);
  endtask

  // Monitor: peeks the head while a beat stalls, pops on ack, write-back and done.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_BEAT) unexpected("beat");
        else begin
          mon_ev = exp_q[0];
          check("reg_counter", 32'(REG_COUNTER), 32'(mon_ev.reg_idx));
          check("mem_addr", mem_addr, mon_ev.value);
          check("mem_we", 32'(mem_we), 32'(mon_ev.we));
          check("lsm_rd_mux", 32'(LSM_RD_MUX), 32'(mon_ev.ld));
          check("latch_reg", 32'(LATCH_REG), 32'(mon_ev.ld && mem_ack));
          check("pc_loaded", 32'(PC_LOADED), 32'(mon_ev.pcl && mem_ack));
          if (mem_ack) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_strobes", 32'({mem_we, LSM_RD_MUX, LATCH_REG, PC_LOADED}), 32'd0);
      end
      if (WRITE_BACK) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_WB) unexpected("write_back");
        else begin
          check("wb_data", WB_DATA, exp_q[0].value);
          void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) unexpected("done");
        else begin
          check("busy_in_done", 32'(busy), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Runs one sequence; ack from a pattern (bit per cycle after start) or random with ack_pct.
  task automatic run_seq(input logic [31:0] ir, input logic [31:0] base,
                         input bit use_pat, input logic [63:0] ack_pat, input int ack_pct);
    int lat, cyc, stalls;
    bit seen;
    model(ir, base, lat);
    @(posedge clk); #1;
    IR = ir; BASE = base; start = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cyc = 0; stalls = 0; seen = 0;
    while (!seen && cyc < 200) begin
      cyc++;
      mem_ack = use_pat ? ack_pat[(cyc > 64) ? 63 : cyc - 1] : ($urandom_range(0, 99) < ack_pct);
      // Starts offered while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      IR = $urandom; BASE = $urandom;
      @(negedge clk);
      if (mem_req && !mem_ack) stalls++;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (!seen) exp_q.delete();
    check("latency", 32'(cyc), 32'(lat + stalls));
    @(posedge clk); #1;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_after", 32'({busy, done, mem_req, WRITE_BACK}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bits"}, 32'({mem_req, mem_we, LSM_RD_MUX, LATCH_REG, WRITE_BACK,
                               PC_LOADED, busy, done}), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_reg_counter"}, 32'(REG_COUNTER), 32'd0);
    check({tag, "_wb_data"}, WB_DATA, 32'd0);
  endtask

  localparam logic [63:0] ACK_ALL   = '1;
  localparam logic [63:0] ACK_STALL = 64'hFFFF_FFFF_FFFF_FFF1;

  initial begin
    int lat;
    logic [15:0] list;
    logic [31:0] ir;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; IR = '0; BASE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_seq(32'hE8B0_0016, 32'h0000_1000, 1, ACK_ALL, 100);   // LDMIA R0!,{R1,R2,R4}
    run_seq(32'hE92D_40F0, 32'h0000_2000, 1, ACK_ALL, 100);   // STMDB R13!,{R4-R7,R14}
    run_seq(32'hE8B0_0016, 32'h0000_1000, 1, ACK_STALL, 100); // stall on second beat
    run_seq(32'hE8B0_0000, 32'h0000_1000, 1, ACK_ALL, 100);   // empty list
    run_seq(32'hE8B0_0003, 32'h0000_3000, 1, ACK_ALL, 100);   // base in load list
    run_seq(32'hE890_8000, 32'h0000_4000, 1, ACK_ALL, 100);   // LDMIA R0,{R15}

    // Reset while the second STMDB beat is on the bus.
    model(32'hE92D_40F0, 32'h0000_2000, lat);
    @(posedge clk); #1;
    IR = 32'hE92D_40F0; BASE = 32'h0000_2000; start = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    run_seq(32'hE92D_40F0, 32'h0000_2000, 1, ACK_ALL, 100);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 5))
        0:       list = 16'h0000;
        1:       list = 16'h0001 << $urandom_range(0, 15);
        2:       list = 16'hFFFF;
        default: list = 16'($urandom);
      endcase
      ir = {4'hE, 3'b100, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
            4'($urandom), list};
      run_seq(ir, (t % 7 == 0) ? 32'($urandom_range(0, 15)) << 2 : $urandom,
              0, ACK_ALL, $urandom_range(30, 100));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
